// File: rtl/bsg_buf_skid_pkg.sv
// Shared types and constants for the bsg_buf_skid retiming stage.
package bsg_buf_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } bsg_buf_skid_state_e;

  localparam int bsg_buf_skid_stall_cnt_width_gp = 16;

endpackage

// File: rtl/bsg_buf_skid.sv
// Two-entry skid buffer that retimes a valid/ready bus with a registered ready_o.
// Optional stall cycle counter enabled by defining BSG_BUF_SKID_STALL_CNT_EN.
module bsg_buf_skid
  import bsg_buf_skid_pkg::*;
#(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               ready_i
`ifdef BSG_BUF_SKID_STALL_CNT_EN
  ,
  output logic [bsg_buf_skid_stall_cnt_width_gp-1:0] stall_cnt_o
`endif
);

  bsg_buf_skid_state_e state_r;
  logic [width_p-1:0]  main_r;
  logic [width_p-1:0]  skid_r;
  logic                in_fire_s;
  logic                out_fire_s;

  // Handshake outputs decode only from the state register, never from inputs.
  assign v_o        = (state_r != EMPTY);
  assign ready_o    = (state_r != FULL);
  assign data_o     = main_r;
  assign in_fire_s  = v_i & ready_o;
  assign out_fire_s = v_o & ready_i;

  // State and data registers; the skid entry only fills when main cannot drain.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= EMPTY;
      main_r  <= '0;
      skid_r  <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            main_r  <= data_i;
            state_r <= BUSY;
          end else begin
            state_r <= EMPTY;
          end
        end
        BUSY: begin
          if (in_fire_s && out_fire_s) begin
            main_r  <= data_i;
            state_r <= BUSY;
          end else if (in_fire_s) begin
            skid_r  <= data_i;
            state_r <= FULL;
          end else if (out_fire_s) begin
            state_r <= EMPTY;
          end else begin
            state_r <= BUSY;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            main_r  <= skid_r;
            state_r <= BUSY;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

`ifdef BSG_BUF_SKID_STALL_CNT_EN
  logic [bsg_buf_skid_stall_cnt_width_gp-1:0] stall_cnt_r;

  // Saturating count of cycles where the consumer holds off valid data.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_r <= '0;
    end else if (v_o && !ready_i && (stall_cnt_r != {bsg_buf_skid_stall_cnt_width_gp{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(bsg_buf_skid_stall_cnt_width_gp-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_bsg_buf_skid.sv
// Randomized self-checking bench for bsg_buf_skid against a two-slot queue model.
module tb_bsg_buf_skid;

  logic        clk_i;
  logic        reset_n_i;
  logic [15:0] data_i;
  logic        v_i;
  logic        ready_o;
  logic [15:0] data_o;
  logic        v_o;
  logic        ready_i;
`ifdef BSG_BUF_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int total;
  int bad;
  logic [15:0] model_q[$];

  bsg_buf_skid #(.width_p(16)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (data_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .v_o       (v_o),
    .ready_i   (ready_i)
`ifdef BSG_BUF_SKID_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one cycle of stimulus and advance the queue model across the clock edge.
  task automatic tick(input logic v, input logic [15:0] d, input logic r);
    bit in_f;
    bit out_f;
    v_i     = v;
    data_i  = d;
    ready_i = r;
    in_f    = v && (model_q.size() < 2);
    out_f   = r && (model_q.size() > 0);
    @(posedge clk_i);
    if (out_f) void'(model_q.pop_front());
    if (in_f) model_q.push_back(d);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_reset();
    v_i = 1'b0; data_i = 16'h0000; ready_i = 1'b0;
    reset_n_i = 1'b0;
    #12;
    total++;
    if (v_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 16'h0000) begin
      bad++;
      $display("FAIL reset: v_o=%b ready_o=%b data_o=%h, want 0 1 0000", v_o, ready_o, data_o);
    end
    reset_n_i = 1'b1;
    model_q.delete();
    @(posedge clk_i); #1;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 16'(i + 1), 1'b1);
      total++;
      if (v_o !== 1'b1 || data_o !== 16'(i + 1) || ready_o !== 1'b1) begin
        bad++;
        $display("FAIL stream[%0d]: v_o=%b data_o=%h ready_o=%b, want 1 %h 1", i, v_o, data_o, ready_o, 16'(i + 1));
      end
    end
    tick(1'b0, 16'h0000, 1'b1);
    total++;
    if (v_o !== 1'b0) begin
      bad++;
      $display("FAIL stream_end: v_o=%b want 0", v_o);
    end
  endtask

  task automatic test_skid();
    tick(1'b1, 16'hA5A5, 1'b0);
    tick(1'b1, 16'h5A5A, 1'b0);
    total++;
    if (ready_o !== 1'b0 || v_o !== 1'b1 || data_o !== 16'hA5A5) begin
      bad++;
      $display("FAIL skid_full: ready_o=%b v_o=%b data_o=%h, want 0 1 a5a5", ready_o, v_o, data_o);
    end
    tick(1'b1, 16'hFFFF, 1'b0);
    total++;
    if (ready_o !== 1'b0 || data_o !== 16'hA5A5) begin
      bad++;
      $display("FAIL skid_hold: ready_o=%b data_o=%h, want 0 a5a5", ready_o, data_o);
    end
    tick(1'b0, 16'h0000, 1'b1);
    total++;
    if (ready_o !== 1'b1 || v_o !== 1'b1 || data_o !== 16'h5A5A) begin
      bad++;
      $display("FAIL skid_pop1: ready_o=%b v_o=%b data_o=%h, want 1 1 5a5a", ready_o, v_o, data_o);
    end
    tick(1'b0, 16'h0000, 1'b1);
    total++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL skid_pop2: v_o=%b ready_o=%b, want 0 1", v_o, ready_o);
    end
  endtask

  task automatic test_random();
    logic [15:0] seq;
    logic [15:0] next_out;
    logic [15:0] prev_data;
    logic        prev_stall;
    logic        v;
    logic        r;
    seq = 16'h0100; next_out = 16'h0100; prev_stall = 1'b0; prev_data = 16'h0000;
    for (int i = 0; i < 1000; i++) begin
      v = 1'($urandom % 2);
      r = 1'($urandom % 2);
      ready_i = r;
      #1;
      total++;
      if (v_o !== (model_q.size() > 0) || ready_o !== (model_q.size() < 2) ||
          (model_q.size() > 0 && data_o !== model_q[0])) begin
        bad++;
        $display("FAIL random_model[%0d]: v_o=%b ready_o=%b data_o=%h, want %b %b %h", i, v_o, ready_o, data_o,
                 model_q.size() > 0, model_q.size() < 2, (model_q.size() > 0) ? model_q[0] : 16'h0000);
      end
      if (prev_stall) begin
        total++;
        if (v_o !== 1'b1 || data_o !== prev_data) begin
          bad++;
          $display("FAIL random_stable[%0d]: v_o=%b data_o=%h, want 1 %h", i, v_o, data_o, prev_data);
        end
      end
      if (v_o && r) begin
        total++;
        if (data_o !== next_out) begin
          bad++;
          $display("FAIL random_order[%0d]: data_o=%h want %h", i, data_o, next_out);
        end
        next_out = next_out + 16'h0001;
      end
      prev_stall = v_o && !r;
      prev_data  = data_o;
      if (v && model_q.size() < 2) begin
        tick(1'b1, seq, r);
        seq = seq + 16'h0001;
      end else begin
        tick(v, seq, r);
      end
    end
    drain();
    total++;
    if (next_out + 16'(model_q.size()) > seq || v_o !== 1'b0) begin
      bad++;
      $display("FAIL random_lossless: popped_to=%h sent_to=%h v_o=%b", next_out, seq, v_o);
    end
  endtask

  task automatic test_drain();
    int vcount;
    vcount = 0;
    tick(1'b1, 16'h1234, 1'b1);
    total++;
    if (v_o !== 1'b1 || data_o !== 16'h1234) begin
      bad++;
      $display("FAIL drain_first: v_o=%b data_o=%h, want 1 1234", v_o, data_o);
    end
    if (v_o) vcount++;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'h0000, 1'b1);
      if (v_o) vcount++;
    end
    total++;
    if (vcount != 1) begin
      bad++;
      $display("FAIL drain_count: valid cycles=%0d want 1", vcount);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 16'h1111, 1'b0);
    tick(1'b1, 16'h2222, 1'b0);
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL areset_pre: ready_o=%b want 0", ready_o);
    end
    #3;
    reset_n_i = 1'b0;
    #1;
    total++;
    if (v_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 16'h0000) begin
      bad++;
      $display("FAIL areset: v_o=%b ready_o=%b data_o=%h, want 0 1 0000", v_o, ready_o, data_o);
    end
    model_q.delete();
    #2;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    tick(1'b0, 16'h0000, 1'b1);
    total++;
    if (v_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL areset_after: v_o=%b ready_o=%b, want 0 1", v_o, ready_o);
    end
  endtask

`ifdef BSG_BUF_SKID_STALL_CNT_EN
  task automatic test_stall_cnt();
    reset_n_i = 1'b0;
    #3;
    reset_n_i = 1'b1;
    model_q.delete();
    @(posedge clk_i); #1;
    total++;
    if (stall_cnt_o !== 16'h0000) begin
      bad++;
      $display("FAIL stall_reset: stall_cnt_o=%h want 0000", stall_cnt_o);
    end
    tick(1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 16'h0000, 1'b0);
    total++;
    if (stall_cnt_o !== 16'd5) begin
      bad++;
      $display("FAIL stall_count: stall_cnt_o=%0d want 5", stall_cnt_o);
    end
    repeat (70000) @(posedge clk_i);
    #1;
    total++;
    if (stall_cnt_o !== 16'hFFFF) begin
      bad++;
      $display("FAIL stall_sat: stall_cnt_o=%h want ffff", stall_cnt_o);
    end
    drain();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_streaming();
    test_skid();
    test_random();
    test_drain();
    test_async_reset();
`ifdef BSG_BUF_SKID_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_buf_skid.md
Name: bsg_buf_skid

Overview:
- Registered valid/ready retiming stage that sits directly downstream of the 16-bit bsg_buf bus buffer.
- Accepts the buffered bus, breaks the long combinational path, and presents it to the consumer with full throughput and a registered ready.
- Built as a 2-entry skid buffer (main + skid register), so upstream ready never depends combinationally on downstream ready.

Parameters:
- width_p, 16, data width in bits; legal range 1..1024.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_n_i  input  1  reset; asynchronous assert, active-low.
- data_i  input  width_p  upstream data, output of bsg_buf.
- v_i  input  1  upstream valid.
- ready_o  output  1  upstream ready; a transfer occurs when v_i && ready_o.
- data_o  output  width_p  downstream data, always driven from the main register.
- v_o  output  1  downstream valid.
- ready_i  input  1  downstream ready; a transfer occurs when v_o && ready_i.

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - state=EMPTY; main and skid data registers = 0.
  - v_o=0, ready_o=1, data_o=0.
  - Takes effect immediately, including mid-transfer; any in-flight data is discarded.
- Outputs:
  - v_o = (state != EMPTY).
  - ready_o = (state != FULL).
  - Both decode directly from the state register, with no combinational path from any input.
  - data_o = main register.
- Latency: 1 cycle from accepted input to v_o. Throughput is 1 transfer per cycle when ready_i is held high.
- State EMPTY:
  - in accepted -> main<=data_i, go to BUSY.
  - No input -> stay in EMPTY.
- State BUSY (main valid, skid empty):
  - in and out both fire -> main<=data_i, stay in BUSY.
  - in only -> skid<=data_i, go to FULL.
  - out only -> go to EMPTY.
  - Neither -> hold.
- State FULL (main and skid valid, ready_o=0):
  - out fires -> main<=skid, go to BUSY.
  - Otherwise hold; upstream data is ignored because ready_o=0.
- Ordering: strict FIFO. The skid entry is always older than any later input.
- Stability: while v_o=1 and ready_i=0, data_o and v_o remain stable.
- ready_i may toggle with v_o=0 and has no effect.
- Encoding: state is a 2-bit enum; the illegal value 2'b11 returns to EMPTY on the next clock.

Optional Feature:
- Macro: BSG_BUF_SKID_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o [15:0].
  - Counts cycles with v_o=1 && ready_i=0, saturating at 16'hFFFF.
  - Reset to 0 by reset_n_i.
- When undefined:
  - Port and counter are absent.
  - Datapath behaviour is identical in both configurations.

Decomposition:
- Package bsg_buf_skid_pkg:
  - state enum bsg_buf_skid_state_e {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}.
  - Constant bsg_buf_skid_stall_cnt_width_gp=16.
- No sub-module. The two data registers, the state register and the next-state logic all live in one module.

Test Plan:
- Reset: drive reset_n_i=0 asynchronously mid-cycle while in FULL -> v_o=0, ready_o=1, data_o=0 immediately.
- Streaming: ready_i=1, v_i=1 with data 16'h0001..16'h0008 on consecutive cycles -> data_o shows the same values one cycle later, no bubbles, ready_o stays 1.
- Skid:
  - Send 16'hA5A5 then 16'h5A5A with ready_i=0 -> state FULL, ready_o=0, data_o=16'hA5A5 held.
  - Raise ready_i -> 16'hA5A5 then 16'h5A5A emitted; ready_o returns to 1 one cycle after the first pop.
- Random backpressure: 1000 cycles with random v_i and ready_i at 50% each, incrementing data -> scoreboard shows in-order, lossless, no duplicates; data_o stable during stalls.
- Drain to empty: single item 16'h1234 with ready_i=1 and no further v_i -> v_o high for exactly 1 cycle, then EMPTY.
- Stall counter (macro on): hold v_o=1, ready_i=0 for 70000 cycles -> stall_cnt_o saturates at 16'hFFFF. With the macro off, the module compiles without the port.
